// File: rtl/ex_muldiv_pkg.sv
// ex_muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - md_op_e    : RV funct3 encodings for the M extension (MD_MUL .. MD_REMU)
//   - md_state_e : controller states (MD_IDLE, MD_CALC, MD_FIX, MD_DONE)
//   - FAST_MUL_EN: set when the build defines EX_MULDIV_FAST_MUL_EN, which
//                  replaces the iterative multiplier with a one-shot product.
//   - helpers classifying an op (divide or multiply, operand signedness).
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'd0,
        MD_MULH   = 3'd1,
        MD_MULHSU = 3'd2,
        MD_MULHU  = 3'd3,
        MD_DIV    = 3'd4,
        MD_DIVU   = 3'd5,
        MD_REM    = 3'd6,
        MD_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_e;

`ifdef EX_MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL_EN = 1'b1;
`else
    localparam bit FAST_MUL_EN = 1'b0;
`endif

    // funct3[2] separates the divide group from the multiply group.
    function automatic logic op_is_div(md_op_e op);
        return op[2];
    endfunction

    function automatic logic op_signed_a(md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic op_signed_b(md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: request/write-back bundle between the EX stage and ex_muldiv.
//   Requests : start_i, op_i (funct3), a_i, b_i, w_addr_i, flush_i
//   Status   : busy_o, stall_req_o
//   Writeback: done_o, w_enable_o, w_addr_o, w_data_o
//   master = pipeline side, slave = the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              start_i;
    logic [2:0]        op_i;
    logic [XLEN-1:0]   a_i;
    logic [XLEN-1:0]   b_i;
    logic [REG_AW-1:0] w_addr_i;
    logic              flush_i;
    logic              busy_o;
    logic              stall_req_o;
    logic              done_o;
    logic              w_enable_o;
    logic [REG_AW-1:0] w_addr_o;
    logic [XLEN-1:0]   w_data_o;

    modport master (
        output start_i, op_i, a_i, b_i, w_addr_i, flush_i,
        input  busy_o, stall_req_o, done_o, w_enable_o, w_addr_o, w_data_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, w_addr_i, flush_i,
        output busy_o, stall_req_o, done_o, w_enable_o, w_addr_o, w_data_o
    );
endinterface

// File: rtl/ex_div_step.sv
// ex_div_step: one combinational restoring-division iteration.
//   partial  : current partial remainder (always below divisor)
//   next_bit : next dividend bit shifted in, MSB first
//   divisor  : divisor magnitude
//   rem_next : partial remainder after this iteration
//   q_bit    : quotient bit produced by this iteration
module ex_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] partial,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    assign shifted = {partial, next_bit};
    assign trial   = shifted - {1'b0, divisor};
    // partial < divisor keeps the trial difference inside XLEN+1 signed
    // bits, so its top bit is the borrow.
    assign q_bit    = ~trial[XLEN];
    assign rem_next = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit beside the EX stage.
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : ex_muldiv_if.slave (request, stall/busy status, write-back)
// Multiplies use a shift-add loop over a 2*XLEN accumulator (multiplier LSB
// first); divides use restoring division (ex_div_step), XLEN cycles each.
// Operands are processed as magnitudes; FIX applies the latched signs.
// Build option: EX_MULDIV_FAST_MUL_EN turns multiplies into a single-cycle
// product with the same latency as the divide special cases.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic        clk,
    input logic        rst,
    ex_muldiv_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e         state, next_state;
    md_op_e            op_in, op_q;
    logic [REG_AW-1:0] addr_q;
    logic [XLEN-1:0]   opd_b_q;
    logic [2*XLEN-1:0] acc, acc_step, prod_signed, fast_prod;
    logic [XLEN-1:0]   res_q, res_fix, quo_signed, rem_signed;
    logic              neg_res_q, neg_rem_q;
    logic [CW-1:0]     cnt;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf, short_path, accept;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   rem_next;
    logic              q_bit;
    logic              in_done, wen;

    // Operand decode in IDLE.
    assign op_in      = md_op_e'(bus.op_i);
    assign neg_a      = op_signed_a(op_in) && bus.a_i[XLEN-1];
    assign neg_b      = op_signed_b(op_in) && bus.b_i[XLEN-1];
    assign mag_a      = neg_a ? -bus.a_i : bus.a_i;
    assign mag_b      = neg_b ? -bus.b_i : bus.b_i;
    assign div_zero   = op_is_div(op_in) && (bus.b_i == '0);
    assign div_ovf    = (op_in == MD_DIV || op_in == MD_REM) &&
                        (bus.a_i == MOST_NEG) && (bus.b_i == '1);
    assign fast_prod  = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign short_path = div_zero || div_ovf || (FAST_MUL_EN && !op_is_div(op_in));
    assign accept     = (state == MD_IDLE) && bus.start_i && !bus.flush_i;

    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else     state <= next_state;
    end

    // NOTE: next_state gets its default before the case, so no path through
    // this block leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            MD_IDLE: if (bus.start_i) next_state = short_path ? MD_FIX : MD_CALC;
            MD_CALC: if (cnt == '0)   next_state = MD_FIX;
            MD_FIX:  next_state = MD_DONE;
            MD_DONE: next_state = MD_IDLE;
            default: next_state = MD_IDLE;
        endcase
        // Flush wins over everything, including a same-cycle start.
        if (bus.flush_i) next_state = MD_IDLE;
    end

    ex_div_step #(.XLEN(XLEN)) u_div_step (
        .partial  (acc[2*XLEN-1:XLEN]),
        .next_bit (acc[XLEN-1]),
        .divisor  (opd_b_q),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Accumulator layout is shared: {high, low} holds {partial product,
    // remaining multiplier} or {partial remainder, dividend -> quotient}.
    always_comb begin
        mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd_b_q} : '0);
        if (op_is_div(op_q)) acc_step = {rem_next, acc[XLEN-2:0], q_bit};
        else                 acc_step = {mul_sum, acc[XLEN-1:1]};
    end

    always_comb begin
        prod_signed = neg_res_q ? -acc : acc;
        quo_signed  = neg_res_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_signed  = neg_rem_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        res_fix     = rem_signed;
        case (op_q)
            MD_MUL:                       res_fix = prod_signed[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: res_fix = prod_signed[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              res_fix = quo_signed;
            default:                      res_fix = rem_signed;
        endcase
    end

    // Special cases preload the accumulator with their final quotient and
    // remainder (signs cleared) and pass through FIX, so every result is
    // written from res_q by the same path.
    // NOTE: sequential state uses <= so each register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= MD_MUL;
            addr_q    <= '0;
            opd_b_q   <= '0;
            acc       <= '0;
            res_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            op_q    <= op_in;
            addr_q  <= bus.w_addr_i;
            opd_b_q <= mag_b;
            cnt     <= CW'(XLEN - 1);
            if (div_zero) begin
                acc       <= {bus.a_i, {XLEN{1'b1}}};
                neg_res_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else if (div_ovf) begin
                acc       <= {{XLEN{1'b0}}, bus.a_i};
                neg_res_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else begin
                acc       <= (FAST_MUL_EN && !op_is_div(op_in)) ? fast_prod
                                                                 : {{XLEN{1'b0}}, mag_a};
                neg_res_q <= neg_a ^ neg_b;
                neg_rem_q <= neg_a;
            end
        end else begin
            if (state == MD_CALC) begin
                acc <= acc_step;
                if (cnt != '0) cnt <= cnt - CW'(1);
            end
            if (state == MD_FIX) res_q <= res_fix;
        end
    end

    assign in_done         = (state == MD_DONE) && !bus.flush_i;
    assign wen             = in_done && (addr_q != '0);
    assign bus.busy_o      = (state != MD_IDLE);
    // The pipeline is held through FIX and released in DONE.
    assign bus.stall_req_o = ((state == MD_IDLE) && bus.start_i) ||
                             (state == MD_CALC) || (state == MD_FIX);
    assign bus.done_o      = in_done;
    assign bus.w_enable_o  = wen;
    assign bus.w_addr_o    = wen ? addr_q : '0;
    assign bus.w_data_o    = wen ? res_q : '0;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: self-checking bench for ex_muldiv (XLEN = 32, REG_AW = 5).
// A timeline model (accept edge + latency, 64-bit reference arithmetic)
// predicts every output each cycle; directed operations also check literal
// results, latencies and stall lengths.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
`ifdef EX_MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    logic clk;
    logic rst;

    ex_muldiv_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bus ();

    ex_muldiv #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_total = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0];  end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        if (!op[2]) return MUL_LAT;
        return DIV_LAT;
    endfunction

    // Timeline model: busy from the accept edge until the edge after the
    // result cycle; the result is visible in the cycle after edge accept+lat.
    bit          m_busy = 1'b0;
    int          m_done_edge = 0;
    logic [31:0] m_data = '0;
    logic [4:0]  m_addr = '0;

    always @(posedge clk) begin
        cyc++;
        if (rst || bus.flush_i) begin
            m_busy = 1'b0;
        end else if (m_busy) begin
            if (cyc == m_done_edge + 1) m_busy = 1'b0;
        end else if (bus.start_i) begin
            m_busy      = 1'b1;
            m_done_edge = cyc + model_latency(bus.op_i, bus.a_i, bus.b_i);
            m_data      = model_result(bus.op_i, bus.a_i, bus.b_i);
            m_addr      = bus.w_addr_i;
        end
    end

    // Compare process: every output, every cycle, away from the clock edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_done, exp_wen, exp_stall;
            exp_done  = m_busy && (cyc == m_done_edge) && !bus.flush_i;
            exp_wen   = exp_done && (m_addr != 0);
            exp_stall = (!m_busy && bus.start_i) || (m_busy && cyc < m_done_edge);
            check("cmp_busy", bus.busy_o, m_busy);
            check("cmp_stall", bus.stall_req_o, exp_stall);
            check("cmp_done", bus.done_o, exp_done);
            check("cmp_wen", bus.w_enable_o, exp_wen);
            check("cmp_waddr", bus.w_addr_o, exp_wen ? m_addr : 5'd0);
            check("cmp_wdata", bus.w_data_o, exp_wen ? m_data : 32'd0);
            if (bus.done_o) done_total++;
        end
    end

    // Issue one op from an IDLE cycle (called at posedge+1) and check the
    // literal result, latency and number of stall cycles before done.
    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] addr,
                          input logic [31:0] exp_data, input int exp_lat, input bit hold);
        int t;
        int scnt;
        bit seen;
        bus.start_i  = 1'b1;
        bus.op_i     = op;
        bus.a_i      = a;
        bus.b_i      = b;
        bus.w_addr_i = addr;
        @(negedge clk);
        check({name, "_req_busy"}, bus.busy_o, 1'b0);
        scnt = bus.stall_req_o ? 1 : 0;
        @(posedge clk);
        #1;
        t = cyc;
        if (!hold) bus.start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.done_o) begin
                seen = 1'b1;
                check({name, "_data"}, bus.w_data_o, exp_data);
                check({name, "_wen"}, bus.w_enable_o, addr != 0);
                check({name, "_latency"}, cyc - t, exp_lat);
            end else if (bus.stall_req_o) begin
                scnt++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no done_o within 100 cycles", name);
        end else begin
            check({name, "_stall_cycles"}, scnt, exp_lat + 1);
        end
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Abort a divide after 10 iterations with flush or reset, then restart.
    task automatic abort_test(input bit use_rst);
        int d0;
        d0 = done_total;
        bus.start_i  = 1'b1;
        bus.op_i     = MD_DIV;
        bus.a_i      = 32'd100;
        bus.b_i      = 32'd7;
        bus.w_addr_i = 5'd2;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else         bus.flush_i = 1'b1;
        @(posedge clk);
        #1;
        rst         = 1'b0;
        bus.flush_i = 1'b0;
        run_op(use_rst ? "after_rst" : "after_flush", MD_REMU, 32'd100, 32'd7, 5'd4,
               32'd2, DIV_LAT, 1'b0);
        check(use_rst ? "rst_done_count" : "flush_done_count", done_total - d0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.op_i     = '0;
        bus.a_i      = '0;
        bus.b_i      = '0;
        bus.w_addr_i = '0;
        bus.flush_i  = 1'b0;

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_done", bus.done_o, 1'b0);
        check("rst_wen", bus.w_enable_o, 1'b0);
        check("rst_waddr", bus.w_addr_o, 5'd0);
        check("rst_wdata", bus.w_data_o, 32'd0);
        check("rst_stall_idle", bus.stall_req_o, 1'b0);
        #1;
        bus.start_i = 1'b1;
        @(negedge clk);
        check("rst_stall_start", bus.stall_req_o, 1'b1);
        check("rst_busy_start", bus.busy_o, 1'b0);
        #1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_en = 1'b1;

        // Multiplies.
        run_op("mul_7", MD_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT, 1'b0);
        run_op("mulhu_ff", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        run_op("mulh_ff", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, MUL_LAT, 1'b0);
        run_op("mulhsu_m1x2", MD_MULHSU, 32'hFFFF_FFFF, 32'd2, 5'd8, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        run_op("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, MUL_LAT, 1'b0);
        run_op("mulhsu_min", MD_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, MUL_LAT, 1'b0);
        run_op("mul_zero", MD_MUL, 32'h1234, 32'd0, 5'd11, 32'd0, MUL_LAT, 1'b0);

        // Divides.
        run_op("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 5'd12, 32'hFFFF_FFFD, DIV_LAT, 1'b0);
        run_op("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 5'd13, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        run_op("divu_100_7", MD_DIVU, 32'd100, 32'd7, 5'd14, 32'd14, DIV_LAT, 1'b0);
        run_op("remu_100_7", MD_REMU, 32'd100, 32'd7, 5'd15, 32'd2, DIV_LAT, 1'b0);
        run_op("div_m7_m2", MD_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd16, 32'd3, DIV_LAT, 1'b0);
        run_op("rem_m7_m2", MD_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd17, 32'hFFFF_FFFF, DIV_LAT, 1'b0);
        run_op("divu_max_1", MD_DIVU, 32'hFFFF_FFFF, 32'd1, 5'd18, 32'hFFFF_FFFF, DIV_LAT, 1'b0);

        // Special cases.
        run_op("divu_by0", MD_DIVU, 32'h1234, 32'd0, 5'd19, 32'hFFFF_FFFF, 1, 1'b0);
        run_op("rem_by0", MD_REM, 32'h1234, 32'd0, 5'd20, 32'h1234, 1, 1'b0);
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 1, 1'b0);
        run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 32'd0, 1, 1'b0);

        // Write to x0 is suppressed but still completes.
        run_op("mul_x0", MD_MUL, 32'd3, 32'd4, 5'd0, 32'd0, MUL_LAT, 1'b0);

        // start_i held through the whole operation.
        d0 = done_total;
        run_op("hold_start", MD_MUL, 32'd3, 32'd4, 5'd3, 32'd12, MUL_LAT, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("hold_one_done", done_total - d0, 1);

        // Flush and start together: nothing is accepted.
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        bus.op_i    = MD_DIVU;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        check("flush_start_busy", bus.busy_o, 1'b0);
        @(posedge clk);
        #1;

        // Mid-operation abort by flush, then by reset.
        abort_test(1'b0);
        abort_test(1'b1);

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
